// File: rtl/atm_account_core.sv
// Account back-end for the ATM: ten-entry PIN/balance store with combinational
// lookup and authentication, and a one-cycle registered transaction engine.
module atm_account_core #(
    parameter int NUM_ACCOUNTS = 10,
    parameter int BAL_W        = 32,
    parameter int PIN_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       acc_num,
    input  logic [PIN_W-1:0] pin,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [BAL_W-1:0] amount,
    input  logic [PIN_W-1:0] new_pin,
    output logic [3:0]       acc_index,
    output logic             acc_found,
    output logic             acc_auth,
    output logic             done,
    output logic             success,
    output logic [BAL_W-1:0] balance
);

    typedef enum logic [2:0] {
        OP_BALANCE    = 3'd1,
        OP_WITHDRAW   = 3'd2,
        OP_DEPOSIT    = 3'd3,
        OP_CHANGE_PIN = 3'd4
    } op_e;

    logic [BAL_W-1:0] bal_q [NUM_ACCOUNTS];
    logic [BAL_W-1:0] bal_d [NUM_ACCOUNTS];
    logic [PIN_W-1:0] pin_q [NUM_ACCOUNTS];
    logic [PIN_W-1:0] pin_d [NUM_ACCOUNTS];

    logic             done_q,    done_d;
    logic             success_q, success_d;
    logic [BAL_W-1:0] balance_q, balance_d;

    logic [BAL_W-1:0] cur_bal;
    logic [BAL_W:0]   dep_sum;

    // acc_index is forced to 0 for unknown accounts so the store is never
    // indexed out of range.
    always_comb begin
        acc_found = ({1'b0, acc_num} < 5'(NUM_ACCOUNTS));
        acc_index = acc_found ? acc_num : 4'd0;
        acc_auth  = acc_found && (pin == pin_q[acc_index]);
        cur_bal   = acc_found ? bal_q[acc_index] : '0;
        dep_sum   = {1'b0, cur_bal} + {1'b0, amount};
    end

    always_comb begin
        for (int i = 0; i < NUM_ACCOUNTS; i++) begin
            bal_d[i] = bal_q[i];
            pin_d[i] = pin_q[i];
        end
        done_d    = 1'b0;
        success_d = success_q;
        balance_d = balance_q;

        if (op_valid) begin
            done_d    = 1'b1;
            success_d = 1'b0;
            balance_d = cur_bal;
            if (acc_auth) begin
                case (op)
                    OP_BALANCE: begin
                        success_d = 1'b1;
                    end
                    OP_WITHDRAW: begin
                        if (amount <= cur_bal) begin
                            bal_d[acc_index] = cur_bal - amount;
                            success_d        = 1'b1;
                            balance_d        = cur_bal - amount;
                        end
                    end
                    OP_DEPOSIT: begin
                        if (!dep_sum[BAL_W]) begin
                            bal_d[acc_index] = dep_sum[BAL_W-1:0];
                            success_d        = 1'b1;
                            balance_d        = dep_sum[BAL_W-1:0];
                        end
                    end
                    OP_CHANGE_PIN: begin
                        pin_d[acc_index] = new_pin;
                        success_d        = 1'b1;
                    end
                    default: begin
                        success_d = 1'b0;
                    end
                endcase
            end
        end
    end

    // Default store: balance 1000*(i+1), PIN is digit i repeated.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q    <= 1'b0;
            success_q <= 1'b0;
            balance_q <= '0;
            for (int i = 0; i < NUM_ACCOUNTS; i++) begin
                bal_q[i] <= BAL_W'(1000 * (i + 1));
                pin_q[i] <= PIN_W'({4{4'(i)}});
            end
        end else begin
            done_q    <= done_d;
            success_q <= success_d;
            balance_q <= balance_d;
            for (int i = 0; i < NUM_ACCOUNTS; i++) begin
                bal_q[i] <= bal_d[i];
                pin_q[i] <= pin_d[i];
            end
        end
    end

    assign done    = done_q;
    assign success = success_q;
    assign balance = balance_q;

endmodule

// File: tb/tb_atm_account_core.sv
// Directed bench for atm_account_core: expected results are queued when a
// request is driven and compared when done pulses.
module tb_atm_account_core;

    localparam int N = 10;

    logic        clk;
    logic        rst;
    logic [3:0]  acc_num;
    logic [15:0] pin;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] amount;
    logic [15:0] new_pin;
    logic [3:0]  acc_index;
    logic        acc_found;
    logic        acc_auth;
    logic        done;
    logic        success;
    logic [31:0] balance;

    typedef struct {
        logic        succ;
        logic [31:0] bal;
    } exp_t;

    exp_t        exp_q[$];
    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic [31:0] m_bal [N];
    logic [15:0] m_pin [N];

    atm_account_core dut (
        .clk(clk), .rst(rst), .acc_num(acc_num), .pin(pin),
        .op_valid(op_valid), .op(op), .amount(amount), .new_pin(new_pin),
        .acc_index(acc_index), .acc_found(acc_found), .acc_auth(acc_auth),
        .done(done), .success(success), .balance(balance)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_bal[i] = 32'(1000 * (i + 1));
            m_pin[i] = {4{4'(i)}};
        end
    endtask

    task automatic model_op(input logic [3:0] a, input logic [15:0] p, input logic [2:0] o,
                            input logic [31:0] amt, input logic [15:0] np, output exp_t e);
        logic        fnd;
        logic [32:0] sum;
        fnd    = (a < 4'(N));
        e.succ = 1'b0;
        e.bal  = fnd ? m_bal[a] : 32'd0;
        if (fnd && p == m_pin[a]) begin
            case (o)
                3'd1: e.succ = 1'b1;
                3'd2: if (amt <= m_bal[a]) begin
                    m_bal[a] = m_bal[a] - amt;
                    e.succ   = 1'b1;
                    e.bal    = m_bal[a];
                end
                3'd3: begin
                    sum = {1'b0, m_bal[a]} + {1'b0, amt};
                    if (!sum[32]) begin
                        m_bal[a] = sum[31:0];
                        e.succ   = 1'b1;
                        e.bal    = m_bal[a];
                    end
                end
                3'd4: begin
                    m_pin[a] = np;
                    e.succ   = 1'b1;
                end
                default: e.succ = 1'b0;
            endcase
        end
    endtask

    // Drives one request for the next rising edge and queues its expectation.
    task automatic op_req(input logic [3:0] a, input logic [15:0] p, input logic [2:0] o,
                          input logic [31:0] amt, input logic [15:0] np);
        exp_t e;
        @(negedge clk);
        acc_num  = a;
        pin      = p;
        op       = o;
        amount   = amt;
        new_pin  = np;
        op_valid = 1'b1;
        model_op(a, p, o, amt, np, e);
        exp_q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", 32'(done), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("success", 32'(success), 32'(e.succ));
                check("balance", balance, e.bal);
            end
        end
    end

    initial begin
        rst = 1'b1; op_valid = 1'b0; acc_num = '0; pin = '0;
        op = '0; amount = '0; new_pin = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_done", 32'(done), 32'd0);
        check("rst_success", 32'(success), 32'd0);
        check("rst_balance", balance, 32'd0);
        rst = 1'b0;

        acc_num = 4'd3; pin = 16'h3333; #1;
        check("lk_found3", 32'(acc_found), 32'd1);
        check("lk_auth3", 32'(acc_auth), 32'd1);
        check("lk_index3", 32'(acc_index), 32'd3);
        pin = 16'h1234; #1;
        check("lk_badpin", 32'(acc_auth), 32'd0);
        acc_num = 4'd12; #1;
        check("lk_found12", 32'(acc_found), 32'd0);
        check("lk_index12", 32'(acc_index), 32'd0);
        check("lk_auth12", 32'(acc_auth), 32'd0);

        op_req(4'd0, 16'h0000, 3'd1, 32'd0, 16'h0);
        idle();
        check("done_one_cycle", 32'(done), 32'd1);
        @(negedge clk);
        check("done_cleared", 32'(done), 32'd0);
        check("success_held", 32'(success), 32'd1);
        check("balance_held", balance, 32'd1000);

        op_req(4'd1, 16'h1111, 3'd2, 32'd500, 16'h0);
        op_req(4'd1, 16'h1111, 3'd2, 32'd1600, 16'h0);
        op_req(4'd1, 16'h1111, 3'd2, 32'd1500, 16'h0);
        op_req(4'd9, 16'h9999, 3'd3, 32'd250, 16'h0);
        op_req(4'd2, 16'h2222, 3'd3, 32'hFFFF_FFFF, 16'h0);
        op_req(4'd4, 16'h4444, 3'd4, 32'd0, 16'hBEEF);
        idle();
        acc_num = 4'd4; pin = 16'h4444; #1;
        check("oldpin_auth", 32'(acc_auth), 32'd0);
        pin = 16'hBEEF; #1;
        check("newpin_auth", 32'(acc_auth), 32'd1);

        op_req(4'd4, 16'h4444, 3'd1, 32'd0, 16'h0);
        op_req(4'd4, 16'hBEEF, 3'd1, 32'd0, 16'h0);
        op_req(4'd4, 16'hBEEF, 3'd4, 32'd0, 16'hBEEF);
        op_req(4'd5, 16'h5555, 3'd7, 32'd100, 16'h0);
        op_req(4'd5, 16'h5555, 3'd0, 32'd100, 16'h0);
        op_req(4'd5, 16'h5555, 3'd1, 32'd0, 16'h0);
        op_req(4'd12, 16'h0000, 3'd1, 32'd0, 16'h0);
        op_req(4'd6, 16'h1234, 3'd2, 32'd10, 16'h0);
        op_req(4'd6, 16'h6666, 3'd1, 32'd0, 16'h0);
        op_req(4'd3, 16'h3333, 3'd3, 32'hFFFF_FFFF - 32'd4000, 16'h0);
        op_req(4'd3, 16'h3333, 3'd3, 32'd1, 16'h0);
        op_req(4'd7, 16'h7777, 3'd2, 32'd0, 16'h0);
        op_req(4'd8, 16'h8888, 3'd3, 32'd0, 16'h0);
        idle();
        idle();

        @(negedge clk);
        rst = 1'b1; op_valid = 1'b1;
        acc_num = 4'd1; pin = 16'h1111; op = 3'd2; amount = 32'd0;
        model_reset();
        @(negedge clk);
        rst = 1'b0; op_valid = 1'b0;
        check("rstop_done", 32'(done), 32'd0);
        check("rstop_success", 32'(success), 32'd0);
        check("rstop_balance", balance, 32'd0);

        op_req(4'd1, 16'h1111, 3'd1, 32'd0, 16'h0);
        op_req(4'd9, 16'h9999, 3'd1, 32'd0, 16'h0);
        op_req(4'd4, 16'h4444, 3'd1, 32'd0, 16'h0);
        op_req(4'd3, 16'h3333, 3'd1, 32'd0, 16'h0);
        op_req(4'd2, 16'h2222, 3'd1, 32'd0, 16'h0);
        idle();
        idle();
        check("pending_results", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
